fp_mul_pipe: RTL

Parametrised, pipelined IEEE-754 binary floating-point multiplier with five selectable rounding modes and overflow/underflow/invalid flags. It generalises the 32-bit single-precision multiplier to any exponent/mantissa width, such as binary16, binary32 or binary64. Operands enter through a valid/ready handshake. Results leave through a valid/ready handshake after a 3-stage pipeline, and the whole pipeline stalls under output backpressure. It sits between the operand sequencer and the result collector in the FP datapath.

---
 rtl/fp_mul_pipe.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: parametrised IEEE-754 binary floating-point multiplier.
// Three register stages (unpack/multiply, normalise, round/pack) behind a
// valid/ready handshake. The entire pipeline stalls while a result is held
// back by the consumer. Subnormal operands are flushed to zero, and underflow
// returns signed zero.
module fp_mul_pipe #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [2:0]             r_mode,
   input  logic [EXP_W+MAN_W:0]   fp_X,
   input  logic [EXP_W+MAN_W:0]   fp_Y,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [EXP_W+MAN_W:0]   fp_Z,
   output logic                   ovrf,
   output logic                   udrf,
   output logic                   inv
);

   localparam int W  = 1 + EXP_W + MAN_W;   // packed word width
   localparam int SW = MAN_W + 1;           // significand width incl. hidden one
   localparam int PW = 2 * SW;              // significand product width
   localparam int XW = EXP_W + 2;           // signed working exponent width

   localparam logic [XW-1:0]    BIAS     = {3'b000, {(EXP_W-1){1'b1}}};
   localparam logic [XW-1:0]    EXP_OVF  = {2'b00, {EXP_W{1'b1}}};
   localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};
   localparam logic [EXP_W-1:0] EXP_MAXF = {{(EXP_W-1){1'b1}}, 1'b0};
   localparam logic [W-1:0]     QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

   typedef enum logic [2:0] {
      RM_RNE = 3'd0,   // nearest, ties to even
      RM_RTZ = 3'd1,   // toward zero
      RM_RDN = 3'd2,   // toward -inf
      RM_RUP = 3'd3,   // toward +inf
      RM_RNA = 3'd4    // nearest, ties away from zero
   } rmode_e;

   // All stages share one enable, so a stalled output freezes everything.
   logic advance;
   logic out_valid_q;

   assign advance   = !out_valid_q || out_ready;
   assign in_ready  = advance;
   assign out_valid = out_valid_q;

   // ---------------- S1: unpack, classify, multiply ----------------
   logic [EXP_W-1:0] x_exp, y_exp;
   logic [MAN_W-1:0] x_frac, y_frac;
   logic             x_zero, y_zero, x_inf, y_inf, x_nan, y_nan;

   assign x_exp  = fp_X[W-2 -: EXP_W];
   assign y_exp  = fp_Y[W-2 -: EXP_W];
   assign x_frac = fp_X[MAN_W-1:0];
   assign y_frac = fp_Y[MAN_W-1:0];
   assign x_zero = (x_exp == '0);
   assign y_zero = (y_exp == '0);
   assign x_inf  = (x_exp == EXP_ONES) && (x_frac == '0);
   assign y_inf  = (y_exp == EXP_ONES) && (y_frac == '0);
   assign x_nan  = (x_exp == EXP_ONES) && (x_frac != '0);
   assign y_nan  = (y_exp == EXP_ONES) && (y_frac != '0);

   logic          s1_valid_q;
   logic          s1_sign_q,     s1_sign_d;
   logic [PW-1:0] s1_prod_q,     s1_prod_d;
   logic [XW-1:0] s1_exp_q,      s1_exp_d;
   rmode_e        s1_rm_q,       s1_rm_d;
   logic          s1_spec_q,     s1_spec_d;
   logic [W-1:0]  s1_spec_z_q,   s1_spec_z_d;
   logic          s1_spec_inv_q, s1_spec_inv_d;

   // Decode operands; resolve NaN/inf/zero here so later stages only bypass.
   always_comb begin
      s1_sign_d     = fp_X[W-1] ^ fp_Y[W-1];
      s1_prod_d     = {{SW{1'b0}}, 1'b1, x_frac} * {{SW{1'b0}}, 1'b1, y_frac};
      s1_exp_d      = {2'b00, x_exp} + {2'b00, y_exp} - BIAS;
      s1_rm_d       = (r_mode > 3'd4) ? RM_RNE : rmode_e'(r_mode);
      s1_spec_d     = 1'b1;
      s1_spec_z_d   = '0;
      s1_spec_inv_d = 1'b0;
      if (x_nan || y_nan) begin
         s1_spec_z_d = QNAN;
      end else if ((x_inf && y_zero) || (y_inf && x_zero)) begin
         s1_spec_z_d   = QNAN;
         s1_spec_inv_d = 1'b1;
      end else if (x_inf || y_inf) begin
         s1_spec_z_d = {s1_sign_d, EXP_ONES, {MAN_W{1'b0}}};
      end else if (x_zero || y_zero) begin
         s1_spec_z_d = {s1_sign_d, {(W-1){1'b0}}};
      end else begin
         s1_spec_d = 1'b0;
      end
   end

   // S1 pipeline register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q    <= 1'b0;
         s1_sign_q     <= 1'b0;
         s1_prod_q     <= '0;
         s1_exp_q      <= '0;
         s1_rm_q       <= RM_RNE;
         s1_spec_q     <= 1'b0;
         s1_spec_z_q   <= '0;
         s1_spec_inv_q <= 1'b0;
      end else if (advance) begin
         s1_valid_q    <= in_valid;
         s1_sign_q     <= s1_sign_d;
         s1_prod_q     <= s1_prod_d;
         s1_exp_q      <= s1_exp_d;
         s1_rm_q       <= s1_rm_d;
         s1_spec_q     <= s1_spec_d;
         s1_spec_z_q   <= s1_spec_z_d;
         s1_spec_inv_q <= s1_spec_inv_d;
      end
   end

   // ---------------- S2: normalise and extract G/R/S ----------------
   logic [PW-2:0]    norm;   // product below the leading one, left aligned
   logic [XW-1:0]    s2_exp_d,  s2_exp_q;
   logic [MAN_W-1:0] s2_frac_d, s2_frac_q;
   logic             s2_g_d, s2_r_d, s2_s_d, s2_g_q, s2_r_q, s2_s_q;
   logic             s2_valid_q, s2_sign_q, s2_spec_q, s2_spec_inv_q;
   rmode_e           s2_rm_q;
   logic [W-1:0]     s2_spec_z_q;

   // The product of two normal significands is in [1,4); drop the leading one.
   always_comb begin
      if (s1_prod_q[PW-1]) begin
         norm     = s1_prod_q[PW-2:0];
         s2_exp_d = s1_exp_q + XW'(1);
      end else begin
         norm     = {s1_prod_q[PW-3:0], 1'b0};
         s2_exp_d = s1_exp_q;
      end
      s2_frac_d = norm[PW-2 -: MAN_W];
      s2_g_d    = norm[PW-2-MAN_W];
      s2_r_d    = norm[PW-3-MAN_W];
      s2_s_d    = |norm[PW-4-MAN_W:0];
   end

   // S2 pipeline register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid_q    <= 1'b0;
         s2_sign_q     <= 1'b0;
         s2_exp_q      <= '0;
         s2_frac_q     <= '0;
         s2_g_q        <= 1'b0;
         s2_r_q        <= 1'b0;
         s2_s_q        <= 1'b0;
         s2_rm_q       <= RM_RNE;
         s2_spec_q     <= 1'b0;
         s2_spec_z_q   <= '0;
         s2_spec_inv_q <= 1'b0;
      end else if (advance) begin
         s2_valid_q    <= s1_valid_q;
         s2_sign_q     <= s1_sign_q;
         s2_exp_q      <= s2_exp_d;
         s2_frac_q     <= s2_frac_d;
         s2_g_q        <= s2_g_d;
         s2_r_q        <= s2_r_d;
         s2_s_q        <= s2_s_d;
         s2_rm_q       <= s1_rm_q;
         s2_spec_q     <= s1_spec_q;
         s2_spec_z_q   <= s1_spec_z_q;
         s2_spec_inv_q <= s1_spec_inv_q;
      end
   end

   // ---------------- S3: round, range check, pack ----------------
   logic           inc, to_inf, under, over, inexact;
   logic [MAN_W:0] frac_rnd;
   logic [XW-1:0]  exp_rnd;
   logic [W-1:0]   z_d;
   logic           ovrf_d, udrf_d, inv_d;
   logic [W-1:0]   fp_Z_q;
   logic           ovrf_q, udrf_q, inv_q;

   // Rounding increment, carry renormalisation and overflow/underflow selection.
   always_comb begin
      inexact = s2_g_q | s2_r_q | s2_s_q;
      case (s2_rm_q)
         RM_RNE:  inc = s2_g_q & (s2_r_q | s2_s_q | s2_frac_q[0]);
         RM_RTZ:  inc = 1'b0;
         RM_RDN:  inc = s2_sign_q & inexact;
         RM_RUP:  inc = ~s2_sign_q & inexact;
         RM_RNA:  inc = s2_g_q;
         default: inc = 1'b0;
      endcase
      // A carry out leaves the fraction bits at zero, i.e. exactly 1.0.
      frac_rnd = {1'b0, s2_frac_q} + {{MAN_W{1'b0}}, inc};
      exp_rnd  = s2_exp_q + {{(XW-1){1'b0}}, frac_rnd[MAN_W]};
      under    = s2_exp_q[XW-1] || (s2_exp_q == '0);
      over     = !exp_rnd[XW-1] && (exp_rnd >= EXP_OVF);
      case (s2_rm_q)
         RM_RTZ:  to_inf = 1'b0;
         RM_RDN:  to_inf = s2_sign_q;
         RM_RUP:  to_inf = ~s2_sign_q;
         default: to_inf = 1'b1;
      endcase
      z_d    = {s2_sign_q, exp_rnd[EXP_W-1:0], frac_rnd[MAN_W-1:0]};
      ovrf_d = 1'b0;
      udrf_d = 1'b0;
      inv_d  = 1'b0;
      if (s2_spec_q) begin
         z_d   = s2_spec_z_q;
         inv_d = s2_spec_inv_q;
      end else if (under) begin
         z_d    = {s2_sign_q, {(W-1){1'b0}}};
         udrf_d = 1'b1;
      end else if (over) begin
         ovrf_d = 1'b1;
         z_d    = to_inf ? {s2_sign_q, EXP_ONES, {MAN_W{1'b0}}}
                         : {s2_sign_q, EXP_MAXF, {MAN_W{1'b1}}};
      end
   end

   // Output register; held stable while the consumer stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         fp_Z_q      <= '0;
         ovrf_q      <= 1'b0;
         udrf_q      <= 1'b0;
         inv_q       <= 1'b0;
      end else if (advance) begin
         out_valid_q <= s2_valid_q;
         fp_Z_q      <= z_d;
         ovrf_q      <= ovrf_d;
         udrf_q      <= udrf_d;
         inv_q       <= inv_d;
      end
   end

   assign fp_Z = fp_Z_q;
   assign ovrf = ovrf_q;
   assign udrf = udrf_q;
   assign inv  = inv_q;

endmodule
